alu_flags_stage: RTL and testbench
==================================

Name: alu_flags_stage

Overview:
- Registered stage directly downstream of the ALU adder.
- Captures the adder sum and carry-out into the ALU result pipeline register and computes the Carry/Zero/Sign/Overflow flags into the architectural flags register.
- Registered Carry is fed back as the adder's CarryFlag input, closing the ADC/SBC chain.
- Supports pipeline stall and flush, flags load from the data bus (pop flags), and Zero chaining for multi-byte arithmetic.

Parameters:
- DATA_W, 8, datapath width of result and operands.
- FLAGS_RST, 4'b0000, reset value of flags {O,S,Z,C}.

Ports:
- clk  input  1  system clock, all state on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- Stall  input  1  hold all state this cycle.
- Flush  input  1  squash the instruction entering this cycle.
- ValidIn  input  1  AdderOut/CarryOut carry a live ALU op this cycle.
- AdderOut  input  DATA_W  sum from adder.
- CarryOut  input  1  carry-out from adder.
- LHSMsb  input  1  bit DATA_W-1 of adder LHS.
- RHSMsb  input  1  bit DATA_W-1 of adder RHS, post-inversion as applied to the adder.
- FlagWrite  input  1  the live op updates flags.
- ZeroChain  input  1  Z accumulates across bytes (ADC/SBC high byte).
- FlagLoad  input  1  load flags from FlagLoadData.
- FlagLoadData  input  4  {O,S,Z,C} from data bus.
- ResultOut  output  DATA_W  registered result.
- ResultValid  output  1  ResultOut holds a live result.
- Flags  output  4  {O,S,Z,C} architectural flags.
- CarryFlag  output  1  equals Flags[0]; drives adder CarryFlag.

Behaviour:
- Async reset (rst_n low):
  - ResultOut=0, ResultValid=0, Flags=FLAGS_RST, CarryFlag=FLAGS_RST[0].
  - Takes effect immediately, mid-operation included.
  - First update occurs on the first rising clk edge after rst_n deasserts.
- Latency: 1 cycle. Inputs sampled at edge N appear on ResultOut/Flags after edge N.
- Flag equations, evaluated from inputs at the sampling edge:
  - Cn = CarryOut.
  - Sn = AdderOut[DATA_W-1].
  - Zr = (AdderOut == 0).
  - Zn = ZeroChain ? (Z & Zr) : Zr, where Z is the current registered flag.
  - On = (LHSMsb == RHSMsb) & (AdderOut[DATA_W-1] != LHSMsb).
- Per-edge priority, highest first:
  1. Stall=1: all registers hold. Flush, FlagLoad and FlagWrite are ignored that cycle.
  2. Flush=1: ResultValid<=0, ResultOut holds, Flags hold. FlagLoad is also squashed.
  3. FlagLoad=1: Flags<=FlagLoadData. ResultValid<=ValidIn, ResultOut<=AdderOut if ValidIn. A coincident FlagWrite is ignored, load wins.
  4. ValidIn=1: ResultOut<=AdderOut, ResultValid<=1. If FlagWrite=1 then Flags<={On,Sn,Zn,Cn}, else Flags hold.
  5. ValidIn=0: ResultValid<=0, ResultOut holds, Flags hold. FlagWrite is ignored.
- CarryFlag is purely Flags[0], with no combinational path from CarryOut. A back-to-back ADC therefore sees the carry of the previous op only after the edge.
- Arithmetic wraps modulo 2^DATA_W, with no saturation.
- Zr is computed on AdderOut only; CarryOut is excluded. 0xFF+0x01 gives Z=1, C=1.
- ZeroChain with FlagWrite=0 has no effect.
- Stall held for multiple cycles keeps all outputs constant. On release, the first non-stalled edge samples the inputs present on that edge.

Test Plan:
- Reset then ADD: rst_n low while Flags previously 4'b1111 -> Flags=0000 immediately. Then ValidIn=1, FlagWrite=1, AdderOut=0x00, CarryOut=1, LHSMsb=1, RHSMsb=1 -> ResultOut=0x00, Flags={O=1,S=0,Z=1,C=1}, CarryFlag=1.
- Signed overflow: AdderOut=0x80, CarryOut=0, LHSMsb=0, RHSMsb=0 (0x7F+0x01) -> Flags=4'b1100, ResultValid=1 after one edge.
- Zero chain: low byte AdderOut=0x00 (Z=1), then high byte ZeroChain=1, AdderOut=0x01 -> Z=0. Repeat with high byte 0x00 -> Z=1. Repeat with low byte 0x05, high byte 0x00 -> Z=0.
- Stall/flush: Stall=1 with ValidIn=1, FlagWrite=1, AdderOut=0x55 -> ResultOut/Flags unchanged for 3 cycles. Then Flush=1 -> ResultValid=0, Flags unchanged.
- Load vs write collision: FlagLoad=1, FlagLoadData=4'b1010, FlagWrite=1, AdderOut=0x00, CarryOut=1 -> Flags=1010, ResultOut=0x00, CarryFlag=0.
- Carry feedback: op1 CarryOut=1 with FlagWrite -> CarryFlag=1 from next cycle. op2 with FlagWrite=0 -> CarryFlag stays 1.

Source files
------------

// File: rtl/alu_flags_stage.sv
// ALU result/flags pipeline stage: registers the adder sum and updates the {O,S,Z,C} flags.
// The registered carry feeds back to the adder for ADC/SBC chaining.
module alu_flags_stage #(
    parameter int unsigned DATA_W    = 8,
    parameter logic [3:0]  FLAGS_RST = 4'b0000
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              Stall,
    input  logic              Flush,
    input  logic              ValidIn,
    input  logic [DATA_W-1:0] AdderOut,
    input  logic              CarryOut,
    input  logic              LHSMsb,
    input  logic              RHSMsb,
    input  logic              FlagWrite,
    input  logic              ZeroChain,
    input  logic              FlagLoad,
    input  logic [3:0]        FlagLoadData,
    output logic [DATA_W-1:0] ResultOut,
    output logic              ResultValid,
    output logic [3:0]        Flags,
    output logic              CarryFlag
);

    localparam int unsigned FLAG_C = 0;
    localparam int unsigned FLAG_Z = 1;
    localparam int unsigned FLAG_S = 2;
    localparam int unsigned FLAG_O = 3;

    logic [DATA_W-1:0] result_q, result_d;
    logic              valid_q,  valid_d;
    logic [3:0]        flags_q,  flags_d;

    logic              cn, sn, zr, zn, on;
    logic [3:0]        alu_flags;

    // Flags produced by the live ALU op; Z may accumulate across bytes.
    always_comb begin
        cn        = CarryOut;
        sn        = AdderOut[DATA_W-1];
        zr        = (AdderOut == '0);
        zn        = ZeroChain ? (flags_q[FLAG_Z] & zr) : zr;
        on        = (LHSMsb == RHSMsb) & (AdderOut[DATA_W-1] != LHSMsb);
        alu_flags = '0;
        alu_flags[FLAG_O] = on;
        alu_flags[FLAG_S] = sn;
        alu_flags[FLAG_Z] = zn;
        alu_flags[FLAG_C] = cn;
    end

    // Next state: stall > flush > flag load > live op > bubble.
    always_comb begin
        result_d = result_q;
        valid_d  = valid_q;
        flags_d  = flags_q;
        if (!Stall) begin
            if (Flush) begin
                valid_d = 1'b0;
            end else if (FlagLoad) begin
                flags_d = FlagLoadData;
                valid_d = ValidIn;
                if (ValidIn) begin
                    result_d = AdderOut;
                end
            end else if (ValidIn) begin
                result_d = AdderOut;
                valid_d  = 1'b1;
                if (FlagWrite) begin
                    flags_d = alu_flags;
                end
            end else begin
                valid_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            result_q <= '0;
            valid_q  <= 1'b0;
            flags_q  <= FLAGS_RST;
        end else begin
            result_q <= result_d;
            valid_q  <= valid_d;
            flags_q  <= flags_d;
        end
    end

    assign ResultOut   = result_q;
    assign ResultValid = valid_q;
    assign Flags       = flags_q;
    // Registered carry only: no combinational path from CarryOut back to the adder.
    assign CarryFlag   = flags_q[FLAG_C];

endmodule

// File: tb/tb_alu_flags_stage.sv
// Bench for alu_flags_stage: operand-level reference model, per-cycle compare, directed pins, random traffic.
module tb_alu_flags_stage;

    localparam int unsigned DATA_W = 8;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              Stall, Flush, ValidIn, CarryOut, LHSMsb, RHSMsb;
    logic              FlagWrite, ZeroChain, FlagLoad;
    logic [DATA_W-1:0] AdderOut;
    logic [3:0]        FlagLoadData;
    logic [DATA_W-1:0] ResultOut;
    logic              ResultValid;
    logic [3:0]        Flags;
    logic              CarryFlag;

    // Operand-level view of the op being presented (the "adder" lives in the bench)
    logic [DATA_W-1:0] op_lhs, op_rhs;
    logic              op_cin;

    int checks = 0;
    int errors = 0;
    bit cmp_en = 1'b0;

    // Reference model state
    logic [DATA_W-1:0] m_result;
    logic              m_valid;
    logic [3:0]        m_flags;

    alu_flags_stage #(.DATA_W(DATA_W), .FLAGS_RST(4'b0000)) dut (
        .clk(clk), .rst_n(rst_n), .Stall(Stall), .Flush(Flush), .ValidIn(ValidIn),
        .AdderOut(AdderOut), .CarryOut(CarryOut), .LHSMsb(LHSMsb), .RHSMsb(RHSMsb),
        .FlagWrite(FlagWrite), .ZeroChain(ZeroChain), .FlagLoad(FlagLoad),
        .FlagLoadData(FlagLoadData), .ResultOut(ResultOut), .ResultValid(ResultValid),
        .Flags(Flags), .CarryFlag(CarryFlag)
    );

    always #5 clk = ~clk;

    // Bench-side adder: sum and carry from integer arithmetic.
    always_comb begin
        logic [DATA_W:0] full;
        full     = {1'b0, op_lhs} + {1'b0, op_rhs} + (DATA_W+1)'(op_cin);
        AdderOut = full[DATA_W-1:0];
        CarryOut = full[DATA_W];
        LHSMsb   = op_lhs[DATA_W-1];
        RHSMsb   = op_rhs[DATA_W-1];
    end

    // Model: flags from signed/unsigned integer results of the operands.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_result = '0;
            m_valid  = 1'b0;
            m_flags  = 4'b0000;
        end else if (!Stall) begin
            if (Flush) begin
                m_valid = 1'b0;
            end else if (FlagLoad) begin
                m_flags = FlagLoadData;
                m_valid = ValidIn;
                if (ValidIn) m_result = DATA_W'(int'(op_lhs) + int'(op_rhs) + int'(op_cin));
            end else if (ValidIn) begin
                int usum, ssum;
                logic o, s, z, c;
                usum = int'(op_lhs) + int'(op_rhs) + int'(op_cin);
                ssum = int'($signed(op_lhs)) + int'($signed(op_rhs)) + int'(op_cin);
                c = (usum >= 256);
                z = ((usum % 256) == 0);
                s = ((usum % 256) >= 128);
                o = (ssum > 127) || (ssum < -128);
                m_result = DATA_W'(usum % 256);
                m_valid  = 1'b1;
                if (FlagWrite) begin
                    if (ZeroChain) z = z & m_flags[1];
                    m_flags = {o, s, z, c};
                end
            end else begin
                m_valid = 1'b0;
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Per-cycle comparison of every output against the model.
    always @(negedge clk) begin
        if (cmp_en) begin
            check("model_result", 32'(ResultOut), 32'(m_result));
            check("model_valid", 32'(ResultValid), 32'(m_valid));
            check("model_flags", 32'(Flags), 32'(m_flags));
            check("model_carryflag", 32'(CarryFlag), 32'(m_flags[0]));
        end
    end

    task automatic idle_inputs();
        Stall = 0; Flush = 0; ValidIn = 0; FlagWrite = 0; ZeroChain = 0;
        FlagLoad = 0; FlagLoadData = 4'h0; op_lhs = '0; op_rhs = '0; op_cin = 0;
    endtask

    // Present one cycle of inputs at negedge, let one rising edge pass, return at the next negedge.
    task automatic step(input logic st, input logic fl, input logic v, input logic fw,
                        input logic zc, input logic ld, input logic [3:0] ldd,
                        input logic [7:0] a, input logic [7:0] b, input logic ci);
        Stall = st; Flush = fl; ValidIn = v; FlagWrite = fw; ZeroChain = zc;
        FlagLoad = ld; FlagLoadData = ldd; op_lhs = a; op_rhs = b; op_cin = ci;
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        idle_inputs();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_result", 32'(ResultOut), 32'h00);
        check("reset_valid", 32'(ResultValid), 32'h0);
        check("reset_flags", 32'(Flags), 32'h0);
        rst_n = 1'b1;
        cmp_en = 1'b1;

        // Load 1111, then reset asynchronously mid-cycle.
        step(0,0,0,0,0,1,4'b1111,8'h00,8'h00,0);
        check("load_1111", 32'(Flags), 32'hF);
        idle_inputs();
        #2 rst_n = 1'b0;
        #1;
        check("async_rst_flags", 32'(Flags), 32'h0);
        check("async_rst_carry", 32'(CarryFlag), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;

        // 0x80+0x80: result 0, O=1 S=0 Z=1 C=1
        step(0,0,1,1,0,0,4'h0,8'h80,8'h80,0);
        check("add_result", 32'(ResultOut), 32'h00);
        check("add_flags", 32'(Flags), 32'b1011);
        check("add_carryflag", 32'(CarryFlag), 32'h1);

        // 0x7F+0x01: signed overflow
        step(0,0,1,1,0,0,4'h0,8'h7F,8'h01,0);
        check("ovf_flags", 32'(Flags), 32'b1100);
        check("ovf_valid", 32'(ResultValid), 32'h1);

        // Zero chaining across two bytes
        step(0,0,1,1,0,0,4'h0,8'h00,8'h00,0);
        check("zc_lo0_z", 32'(Flags[1]), 32'h1);
        step(0,0,1,1,1,0,4'h0,8'h00,8'h01,0);
        check("zc_hi1_z", 32'(Flags[1]), 32'h0);
        step(0,0,1,1,0,0,4'h0,8'h00,8'h00,0);
        step(0,0,1,1,1,0,4'h0,8'h00,8'h00,0);
        check("zc_hi0_z", 32'(Flags[1]), 32'h1);
        step(0,0,1,1,0,0,4'h0,8'h02,8'h03,0);
        step(0,0,1,1,1,0,4'h0,8'h00,8'h00,0);
        check("zc_lo5_hi0_z", 32'(Flags[1]), 32'h0);
        check("zc_result", 32'(ResultOut), 32'h00);

        // Stall for 3 cycles with a live op presented, then flush
        for (int i = 0; i < 3; i++) begin
            step(1,0,1,1,0,0,4'h0,8'h55,8'h00,0);
            check("stall_result", 32'(ResultOut), 32'h00);
            check("stall_flags", 32'(Flags), 32'h0);
        end
        step(0,1,1,1,0,1,4'hF,8'h55,8'h00,0);
        check("flush_valid", 32'(ResultValid), 32'h0);
        check("flush_flags", 32'(Flags), 32'h0);
        check("flush_result", 32'(ResultOut), 32'h00);

        // Load beats a coincident write
        step(0,0,1,1,0,1,4'b1010,8'hFF,8'h01,0);
        check("collide_flags", 32'(Flags), 32'b1010);
        check("collide_result", 32'(ResultOut), 32'h00);
        check("collide_carry", 32'(CarryFlag), 32'h0);

        // Carry feedback survives a non-flag-writing op
        step(0,0,1,1,0,0,4'h0,8'hFF,8'h02,0);
        check("cfb_carry1", 32'(CarryFlag), 32'h1);
        step(0,0,1,0,1,0,4'h0,8'h01,8'h01,0);
        check("cfb_carry_hold", 32'(CarryFlag), 32'h1);
        check("cfb_result", 32'(ResultOut), 32'h02);

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            logic [7:0] a, b;
            a = 8'($urandom);
            b = 8'($urandom);
            if ($urandom_range(0, 4) == 0) begin a = '0; b = '0; end
            if ($urandom_range(0, 9) == 0) b = 8'(-int'(a));
            step(logic'($urandom_range(0, 9) == 0), logic'($urandom_range(0, 9) == 0),
                 logic'($urandom_range(0, 9) < 7), logic'($urandom_range(0, 9) < 6),
                 logic'($urandom_range(0, 9) < 3), logic'($urandom_range(0, 9) == 0),
                 4'($urandom), a, b, logic'($urandom_range(0, 1)));
        end

        cmp_en = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
